// File: rtl/mem_org_pkg.sv
// Shared types and constants for the memory-organisation mode register bank.
package mem_org_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } fsm_state_t;

    localparam int ST_PENDING = 0;
    localparam int ST_IRQ     = 1;

    // STATUS sits directly after the last mode field.
    function automatic int status_offset(input int num_channels);
        return num_channels;
    endfunction

endpackage

// File: rtl/mem_org_channel.sv
// One channel: host-visible shadow mode plus the kernel-visible applied copy.
module mem_org_channel #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_data,
    input  logic          apply,
    output logic [CW-1:0] host_mode,
    output logic [CW-1:0] kernel_mode
);

    logic [CW-1:0] shadow_q, shadow_d;
    logic [CW-1:0] kernel_q, kernel_d;

    always_comb begin
        shadow_d = wr_en ? wr_data : shadow_q;
        kernel_d = apply ? shadow_q : kernel_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            kernel_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            kernel_q <= kernel_d;
        end
    end

    assign host_mode   = shadow_q;
    assign kernel_mode = kernel_q;

endmodule

// File: rtl/mem_org_mode_bank.sv
// Mode register bank: host writes land in shadows at once, kernel copies update only via an idle-gated apply.
// Optional apply-done interrupt enabled by defining MEM_ORG_BANK_IRQ_EN.
module mem_org_mode_bank
    import mem_org_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CONDUIT_WIDTH = 2,
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDR_WIDTH    = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ADDR_WIDTH-1:0]                 slave_address,
    input  logic [WIDTH-1:0]                      slave_writedata,
    input  logic                                  slave_read,
    input  logic                                  slave_write,
    output logic [WIDTH-1:0]                      slave_readdata,
    output logic                                  slave_readdatavalid,
    output logic                                  slave_waitrequest,
    input  logic                                  kernel_idle,
    output logic                                  apply_req,
    output logic [NUM_CHANNELS*CONDUIT_WIDTH-1:0] mem_organization_host,
    output logic [NUM_CHANNELS*CONDUIT_WIDTH-1:0] mem_organization_kernel,
    output logic                                  irq
);

    localparam int CW = CONDUIT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(status_offset(NUM_CHANNELS));

    fsm_state_t state_q, state_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             readdatavalid_q, readdatavalid_d;

    logic rd_acc, wr_acc, mode_wr, status_wr, apply_now, irq_flag;
    logic [NUM_CHANNELS-1:0] ch_wr_en;
    logic [WIDTH-1:0] status_word, rd_mux;

    assign slave_waitrequest = (state_q == APPLY);
    assign apply_now         = (state_q == APPLY);
    assign apply_req         = (state_q == PENDING);

    // A simultaneous read+write is treated as a write only.
    assign wr_acc    = slave_write && !slave_waitrequest;
    assign rd_acc    = slave_read && !slave_write && !slave_waitrequest;
    assign mode_wr   = wr_acc && (slave_address < ADDR_WIDTH'(NUM_CHANNELS));
    assign status_wr = wr_acc && (slave_address == STATUS_ADDR);

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            assign ch_wr_en[gi] = mode_wr && (slave_address == ADDR_WIDTH'(gi));
            mem_org_channel #(.CW(CW)) u_ch (
                .clk         (clk),
                .reset       (reset),
                .wr_en       (ch_wr_en[gi]),
                .wr_data     (slave_writedata[CW-1:0]),
                .apply       (apply_now),
                .host_mode   (mem_organization_host[gi*CW +: CW]),
                .kernel_mode (mem_organization_kernel[gi*CW +: CW])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mode_wr) state_d = PENDING;
            PENDING: if (kernel_idle) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status_word             = '0;
        status_word[ST_PENDING] = (state_q == PENDING);
        status_word[ST_IRQ]     = irq_flag;
        rd_mux                  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (slave_address == ADDR_WIDTH'(i)) rd_mux = WIDTH'(mem_organization_host[i*CW +: CW]);
        end
        if (slave_address == STATUS_ADDR) rd_mux = status_word;
        readdata_d      = rd_acc ? rd_mux : readdata_q;
        readdatavalid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign slave_readdata      = readdata_q;
    assign slave_readdatavalid = readdatavalid_q;

`ifdef MEM_ORG_BANK_IRQ_EN
    logic irq_q, irq_d;

    // Set is applied after clear so a coincident set wins.
    always_comb begin
        irq_d = irq_q;
        if (status_wr && slave_writedata[ST_IRQ]) irq_d = 1'b0;
        if (apply_now) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq_flag = irq_q;
`else
    assign irq_flag = 1'b0;
`endif

    assign irq = irq_flag;

    logic unused_bits;
    assign unused_bits = ^{slave_writedata, status_wr};

endmodule

// File: tb/tb_mem_org_mode_bank.sv
// Self-checking bench for mem_org_mode_bank: directed tables, hand sequences, random vs. model.
module tb_mem_org_mode_bank;

    localparam int W  = 32;
    localparam int CW = 2;
    localparam int NC = 4;
    localparam int AW = 3;
`ifdef MEM_ORG_BANK_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] slave_address;
    logic [W-1:0]  slave_writedata;
    logic          slave_read, slave_write;
    logic [W-1:0]  slave_readdata;
    logic          slave_readdatavalid, slave_waitrequest;
    logic          kernel_idle, apply_req, irq;
    logic [NC*CW-1:0] mem_organization_host, mem_organization_kernel;

    always #5 clk = ~clk;

    mem_org_mode_bank #(.WIDTH(W), .CONDUIT_WIDTH(CW), .NUM_CHANNELS(NC), .ADDR_WIDTH(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .slave_address           (slave_address),
        .slave_writedata         (slave_writedata),
        .slave_read              (slave_read),
        .slave_write             (slave_write),
        .slave_readdata          (slave_readdata),
        .slave_readdatavalid     (slave_readdatavalid),
        .slave_waitrequest       (slave_waitrequest),
        .kernel_idle             (kernel_idle),
        .apply_req               (apply_req),
        .mem_organization_host   (mem_organization_host),
        .mem_organization_kernel (mem_organization_kernel),
        .irq                     (irq)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  exp_rd;
        logic [7:0]    exp_host;
        logic          exp_pend;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        tick();
        slave_write = 1'b0;
        $display("WR addr=%0d data=0x%0h host=0x%0h kernel=0x%0h", a, d, mem_organization_host, mem_organization_kernel);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [W-1:0] d);
        slave_address = a; slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        check("rd_valid", W'(slave_readdatavalid), 32'd1);
        d = slave_readdata;
        $display("RD addr=%0d data=0x%0h", a, d);
        tick();
        check("rd_valid_pulse", W'(slave_readdatavalid), 32'd0);
    endtask

    task automatic settle();
        kernel_idle = 1'b1;
        repeat (4) tick();
    endtask

    // Behavioural model for random phase
    int   m_host[NC], m_kernel[NC];
    bit   m_pend, m_apply, m_irq, m_valid;
    logic [W-1:0] m_rdata;

    function automatic logic [NC*CW-1:0] pack(input int v[NC]);
        logic [NC*CW-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(v[i]);
        return r;
    endfunction

    initial begin
        logic [W-1:0] rd;
        int wcnt;
        int a;
        bit stall, wacc, racc;
        int nh[NC];

        vecs[0] = '{addr: 3'd1, wdata: 32'hFFFF_FFFE, exp_rd: 32'h2, exp_host: 8'h7A, exp_pend: 1'b1};
        vecs[1] = '{addr: 3'd0, wdata: 32'h0000_0005, exp_rd: 32'h1, exp_host: 8'h79, exp_pend: 1'b1};
        vecs[2] = '{addr: 3'd7, wdata: 32'h0000_0003, exp_rd: 32'h0, exp_host: 8'h79, exp_pend: 1'b0};
        vecs[3] = '{addr: 3'd5, wdata: 32'h0000_FFFF, exp_rd: 32'h0, exp_host: 8'h79, exp_pend: 1'b0};
        vecs[4] = '{addr: 3'd2, wdata: 32'h0000_0004, exp_rd: 32'h0, exp_host: 8'h49, exp_pend: 1'b1};
        vecs[5] = '{addr: 3'd3, wdata: 32'h0000_0002, exp_rd: 32'h2, exp_host: 8'h89, exp_pend: 1'b1};

        reset = 1'b1; slave_address = '0; slave_writedata = '0;
        slave_read = 1'b0; slave_write = 1'b0; kernel_idle = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_host", W'(mem_organization_host), 32'h0);
        check("rst_kernel", W'(mem_organization_kernel), 32'h0);
        check("rst_waitreq", W'(slave_waitrequest), 32'h0);
        check("rst_apply_req", W'(apply_req), 32'h0);
        check("rst_irq", W'(irq), 32'h0);
        do_read(3'd4, rd);
        check("rst_status", rd, 32'h0);

        // Kernel busy: host follows, kernel holds
        kernel_idle = 1'b0;
        do_write(3'd2, 32'h3);
        check("t2_host", W'(mem_organization_host), 32'h30);
        check("t2_apply_req", W'(apply_req), 32'h1);
        wcnt = 0;
        repeat (20) begin
            tick();
            if (mem_organization_kernel != '0) wcnt++;
        end
        check("t2_kernel_hold", wcnt, 32'd0);
        do_read(3'd4, rd);
        check("t2_status_pend", rd, 32'h1);
        kernel_idle = 1'b1;
        wcnt = 0;
        repeat (5) begin
            tick();
            if (slave_waitrequest) wcnt++;
        end
        check("t2_wait_cycles", wcnt, 32'd1);
        check("t2_kernel", W'(mem_organization_kernel), 32'h30);
        check("t2_apply_req_done", W'(apply_req), 32'h0);

        // Two writes in PENDING collapse into one apply
        kernel_idle = 1'b0;
        do_write(3'd0, 32'h1);
        do_write(3'd0, 32'h2);
        check("t3_host", W'(mem_organization_host), 32'h32);
        check("t3_kernel_hold", W'(mem_organization_kernel), 32'h30);
        kernel_idle = 1'b1;
        wcnt = 0;
        repeat (6) begin
            tick();
            if (slave_waitrequest) wcnt++;
        end
        check("t3_wait_cycles", wcnt, 32'd1);
        check("t3_kernel", W'(mem_organization_kernel), 32'h32);

        // Latency with kernel_idle held high
        do_write(3'd3, 32'h1);
        check("lat_t1_req", W'(apply_req), 32'h1);
        check("lat_t1_wait", W'(slave_waitrequest), 32'h0);
        check("lat_t1_kernel", W'(mem_organization_kernel), 32'h32);
        tick();
        check("lat_t2_wait", W'(slave_waitrequest), 32'h1);
        check("lat_t2_req", W'(apply_req), 32'h0);
        check("lat_t2_kernel", W'(mem_organization_kernel), 32'h32);
        tick();
        check("lat_t3_wait", W'(slave_waitrequest), 32'h0);
        check("lat_t3_kernel", W'(mem_organization_kernel), 32'h72);

        // Apply-done interrupt and W1C
        check("irq_after_apply", W'(irq), W'(IRQ_EN));
        do_read(3'd4, rd);
        check("status_irq", rd, IRQ_EN ? 32'h2 : 32'h0);
        do_write(3'd4, 32'h2);
        check("irq_cleared", W'(irq), 32'h0);
        check("status_wr_no_pend", W'(apply_req), 32'h0);
        do_read(3'd4, rd);
        check("status_after_clr", rd, 32'h0);

        // Table-driven write/apply/read
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata);
            check($sformatf("tbl%0d_host", i), W'(mem_organization_host), W'(vecs[i].exp_host));
            check($sformatf("tbl%0d_pend", i), W'(apply_req), W'(vecs[i].exp_pend));
            settle();
            check($sformatf("tbl%0d_kernel", i), W'(mem_organization_kernel), W'(vecs[i].exp_host));
            do_read(vecs[i].addr, rd);
            check($sformatf("tbl%0d_rd", i), rd, vecs[i].exp_rd);
        end

        // Read and write together: write wins, no readdatavalid
        slave_address = 3'd0; slave_writedata = 32'h3; slave_read = 1'b1; slave_write = 1'b1;
        tick();
        slave_read = 1'b0; slave_write = 1'b0;
        $display("RDWR addr=0 data=0x3 host=0x%0h", mem_organization_host);
        check("rdwr_no_valid", W'(slave_readdatavalid), 32'h0);
        check("rdwr_host", W'(mem_organization_host), 32'h8B);
        settle();

        // Reset while pending drops the change
        kernel_idle = 1'b0;
        do_write(3'd3, 32'h1);
        check("t5_pend", W'(apply_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_host", W'(mem_organization_host), 32'h0);
        check("t5_kernel", W'(mem_organization_kernel), 32'h0);
        check("t5_apply_req", W'(apply_req), 32'h0);
        kernel_idle = 1'b1;
        wcnt = 0;
        repeat (5) begin
            tick();
            if (slave_waitrequest) wcnt++;
        end
        check("t5_no_apply", wcnt, 32'd0);
        check("t5_kernel_after", W'(mem_organization_kernel), 32'h0);
        check("t5_irq", W'(irq), 32'h0);

        // Randomised run against the model (DUT is fresh from reset)
        for (int i = 0; i < NC; i++) begin m_host[i] = 0; m_kernel[i] = 0; end
        m_pend = 0; m_apply = 0; m_irq = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            slave_write     = ($urandom_range(0, 2) == 0);
            slave_read      = ($urandom_range(0, 2) == 0);
            slave_address   = AW'($urandom_range(0, 7));
            slave_writedata = $urandom;
            kernel_idle     = ($urandom_range(0, 3) == 0);
            a = int'(slave_address);

            stall = m_apply;
            wacc  = slave_write && !stall;
            racc  = slave_read && !slave_write && !stall;
            if (racc) begin
                if (a < NC)       m_rdata = W'(m_host[a]);
                else if (a == NC) m_rdata = W'({m_irq, m_pend});
                else              m_rdata = '0;
            end
            m_valid = racc;
            nh = m_host;
            if (wacc && a < NC) nh[a] = int'(slave_writedata[CW-1:0]);
            if (wacc && a == NC && slave_writedata[1] && IRQ_EN) m_irq = 0;
            if (m_apply) begin
                m_kernel = m_host;
                m_apply  = 0;
                if (IRQ_EN) m_irq = 1;
            end else if (m_pend) begin
                if (kernel_idle) begin m_pend = 0; m_apply = 1; end
            end else if (wacc && a < NC) begin
                m_pend = 1;
            end
            m_host = nh;

            tick();
            if (wacc || racc)
                $display("RND cyc=%0d %s addr=%0d data=0x%0h", cyc, wacc ? "WR" : "RD", a, slave_writedata);
            check("rnd_host", W'(mem_organization_host), W'(pack(m_host)));
            check("rnd_kernel", W'(mem_organization_kernel), W'(pack(m_kernel)));
            check("rnd_apply_req", W'(apply_req), W'(m_pend));
            check("rnd_waitreq", W'(slave_waitrequest), W'(m_apply));
            check("rnd_rdvalid", W'(slave_readdatavalid), W'(m_valid));
            if (m_valid) check("rnd_rdata", slave_readdata, m_rdata);
            check("rnd_irq", W'(irq), W'(m_irq));
        end
        slave_read = 1'b0; slave_write = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
